// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the multi-digit BCD counter controller.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int unsigned MAX_DIGITS = 16;

    // Only the low n nibbles are examined; callers zero-extend narrower vectors.
    function automatic logic is_bcd_vec(input logic [4*MAX_DIGITS-1:0] v,
                                        input int unsigned n);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if ((i < n) && (v[4*i +: 4] > BCD_MAX))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_carry_gen.sv
// Ripple-of-nines enable generator: digit i counts when every lower digit is 9.
module bcd_carry_gen
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] Q,
    input  logic                count_en,
    output logic [DIGITS-1:0]   Enable
);

    logic w_carry;

    always_comb begin
        w_carry = count_en;
        Enable  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            Enable[i] = w_carry;
            w_carry   = w_carry && (Q[4*i +: 4] == BCD_MAX);
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a bank of decade counters: load preset, count on
// tick until the bank reads the target, then pulse done.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                CLK,
    input  logic                MR,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [4*DIGITS-1:0] cmd_preset,
    input  logic [4*DIGITS-1:0] cmd_target,
    input  logic                tick,
    input  logic                pause,
    input  logic                abort,
    input  logic [4*DIGITS-1:0] Q,
    output logic [DIGITS-1:0]   Load,
    output logic [DIGITS-1:0]   Enable,
    output logic [4*DIGITS-1:0] P,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t r_state;
    state_t w_next;

    logic [4*DIGITS-1:0]   r_p;
    logic [4*DIGITS-1:0]   r_target;
    logic                  r_err;
    logic [4*MAX_DIGITS-1:0] w_pre_ext;
    logic [4*MAX_DIGITS-1:0] w_tgt_ext;
    logic                  w_accept;
    logic                  w_cmd_ok;
    logic                  w_match;
    logic                  w_count_en;

    assign w_pre_ext = (4*MAX_DIGITS)'(cmd_preset);
    assign w_tgt_ext = (4*MAX_DIGITS)'(cmd_target);
    assign w_cmd_ok  = is_bcd_vec(w_pre_ext, DIGITS) && is_bcd_vec(w_tgt_ext, DIGITS);
    assign w_accept  = cmd_valid && (r_state == IDLE);
    assign w_match   = (Q == r_target);

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            r_state  <= IDLE;
            r_p      <= '0;
            r_target <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_accept && !w_cmd_ok;
            if (w_accept && w_cmd_ok) begin
                r_p      <= cmd_preset;
                r_target <= cmd_target;
            end
        end
    end

    // Abort outranks a target match, and a match outranks tick.
    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        Load       = '0;
        w_count_en = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept && w_cmd_ok)
                    w_next = LOAD;
            end
            LOAD: begin
                Load   = '1;
                w_next = RUN;
            end
            RUN: begin
                if (abort)
                    w_next = IDLE;
                else if (w_match)
                    w_next = DONE;
                else
                    w_count_en = tick && !pause;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    bcd_carry_gen #(
        .DIGITS (DIGITS)
    ) u_carry (
        .Q        (Q),
        .count_en (w_count_en),
        .Enable   (Enable)
    );

    assign P   = r_p;
    assign err = r_err;

endmodule
